branch_predict_ctrl: RTL and testbench

//  Branch predictor and resolution sequencer around the EX-stage branch decision (Branch = f(funct3, Z/S/V/C)).
//  IF stage: a 2-bit saturating-counter BHT, indexed by PC, supplies a taken/not-taken prediction.
//  EX stage: compares the actual outcome with the carried prediction; on mismatch, redirects the PC and

---
 rtl/branch_predict_ctrl.sv | 123 ++++++++++++
 tb/tb_branch_predict_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Branch predictor (2-bit saturating BHT) and EX-stage resolution sequencer.
// Mispredicts raise a one-cycle redirect and hold flush for a fixed number of advancing cycles.
module branch_predict_ctrl #(
    parameter int unsigned N            = 32,
    parameter int unsigned BHT_IDX      = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     if_pc,
    input  logic             if_is_branch,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [N-1:0]     ex_pc,
    input  logic             ex_pred_taken,
    input  logic             ex_taken,
    input  logic [N-1:0]     ex_target,
    input  logic             stall,
    output logic             redirect,
    output logic [N-1:0]     redirect_pc,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned Entries = 2 ** BHT_IDX;
    localparam int unsigned RemW    = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e            state_q, state_d;
    logic [RemW-1:0]   rem_q, rem_d;
    logic [1:0]        bht [Entries];
    logic [BHT_IDX-1:0] if_idx, ex_idx;
    logic              resolve, mispredict;
    logic [1:0]        ctr_old, ctr_new;

    assign if_idx = if_pc[BHT_IDX+1:2];
    assign ex_idx = ex_pc[BHT_IDX+1:2];

    // Read is the registered value: a same-cycle write is not bypassed.
    assign pred_taken = if_is_branch & bht[if_idx][1];

    assign resolve    = ex_valid & ex_is_branch & ~stall & (state_q == StIdle);
    assign mispredict = resolve & (ex_taken != ex_pred_taken);

    always_comb begin
        ctr_old = bht[ex_idx];
        ctr_new = ctr_old;
        if (ex_taken) begin
            if (ctr_old != 2'b11) ctr_new = ctr_old + 2'b01;
        end else begin
            if (ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Entries; i++) bht[i] <= 2'b01;
        end else if (resolve) begin
            bht[ex_idx] <= ctr_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect       <= 1'b0;
            redirect_pc    <= '0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            redirect <= mispredict;
            if (resolve) branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispredict) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
                redirect_pc    <= ex_taken ? ex_target : ex_pc + N'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        flush   = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mispredict) begin
                    state_d = StFlush;
                    rem_d   = RemW'(FLUSH_CYCLES);
                end
            end
            StFlush: begin
                flush = 1'b1;
                busy  = 1'b1;
                // Stall freezes the countdown so the flush stretches with the pipeline.
                if (!stall) begin
                    if (rem_q == RemW'(1)) begin
                        state_d = StIdle;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - RemW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with hand-computed expectations.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_is_branch;
    logic        pred_taken;
    logic        ex_valid, ex_is_branch, ex_pred_taken, ex_taken, stall;
    logic [31:0] ex_pc, ex_target;
    logic        redirect, flush, busy;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, mispredict_cnt;

    int checks   = 0;
    int failures = 0;

    branch_predict_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_is_branch   (if_is_branch),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .busy           (busy),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic pr, input logic tk,
                          input logic [31:0] tgt);
        ex_valid      = v;
        ex_is_branch  = v;
        ex_pc         = pc;
        ex_pred_taken = pr;
        ex_taken      = tk;
        ex_target     = tgt;
    endtask

    initial begin
        rst = 1'b1;
        if_pc = 32'h100; if_is_branch = 1'b1; stall = 1'b0;
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(); step();
        check_eq("rst_pred", {31'b0, pred_taken}, 32'd0);
        rst = 1'b0;
        step();
        // 1: reset state
        check_eq("r_pred", {31'b0, pred_taken}, 32'd0);
        if_pc = 32'h3c; #1;
        check_eq("r_pred2", {31'b0, pred_taken}, 32'd0);
        check_eq("r_bcnt", {16'b0, branch_cnt}, 32'd0);
        check_eq("r_mcnt", {16'b0, mispredict_cnt}, 32'd0);
        check_eq("r_flush", {31'b0, flush}, 32'd0);
        check_eq("r_redir", {31'b0, redirect}, 32'd0);
        check_eq("r_rpc", redirect_pc, 32'd0);

        // 2: predicted not-taken, actually taken
        set_ex(1'b1, 32'h100, 1'b0, 1'b1, 32'h200);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("t2_redir", {31'b0, redirect}, 32'd1);
        check_eq("t2_rpc", redirect_pc, 32'h200);
        check_eq("t2_flush1", {31'b0, flush}, 32'd1);
        check_eq("t2_busy", {31'b0, busy}, 32'd1);
        check_eq("t2_mcnt", {16'b0, mispredict_cnt}, 32'd1);
        check_eq("t2_bcnt", {16'b0, branch_cnt}, 32'd1);
        step();
        check_eq("t2_redir_off", {31'b0, redirect}, 32'd0);
        check_eq("t2_flush2", {31'b0, flush}, 32'd1);
        check_eq("t2_rpc_hold", redirect_pc, 32'h200);
        step();
        check_eq("t2_flush_off", {31'b0, flush}, 32'd0);
        if_pc = 32'h100; #1;
        check_eq("t2_pred", {31'b0, pred_taken}, 32'd1);
        if_is_branch = 1'b0; #1;
        check_eq("t2_pred_nb", {31'b0, pred_taken}, 32'd0);
        if_is_branch = 1'b1;

        // 3: predicted taken, actually not taken; 0x40 aliases index 0 with 0x100
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 32'h999);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("t3_redir", {31'b0, redirect}, 32'd1);
        check_eq("t3_rpc", redirect_pc, 32'h44);
        check_eq("t3_bcnt", {16'b0, branch_cnt}, 32'd2);
        check_eq("t3_flush1", {31'b0, flush}, 32'd1);
        step();
        check_eq("t3_flush2", {31'b0, flush}, 32'd1);
        step();
        check_eq("t3_flush_off", {31'b0, flush}, 32'd0);
        check_eq("t3_alias_pred", {31'b0, pred_taken}, 32'd0);

        // 4: four correct taken branches at 0x80 saturate index 0 to 11
        if_pc = 32'h80;
        set_ex(1'b1, 32'h80, 1'b1, 1'b1, 32'h1000);
        #1;
        check_eq("t4_collide", {31'b0, pred_taken}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t4_no_redir", {31'b0, redirect}, 32'd0);
        end
        set_ex(1'b1, 32'h80, 1'b0, 1'b0, 32'h1000);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("t4_pred_hyst", {31'b0, pred_taken}, 32'd1);
        check_eq("t4_bcnt", {16'b0, branch_cnt}, 32'd7);
        check_eq("t4_mcnt", {16'b0, mispredict_cnt}, 32'd2);
        check_eq("t4_flush", {31'b0, flush}, 32'd0);

        // 5: mispredict with a 3-cycle stall inside FLUSH; valid branch held throughout
        set_ex(1'b1, 32'h300, 1'b0, 1'b1, 32'h500);
        step();
        check_eq("t5_redir", {31'b0, redirect}, 32'd1);
        check_eq("t5_rpc", redirect_pc, 32'h500);
        for (int i = 0; i < 5; i++) begin
            check_eq("t5_flush_on", {31'b0, flush}, 32'd1);
            stall = (i < 3);
            step();
        end
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("t5_flush_off", {31'b0, flush}, 32'd0);
        check_eq("t5_busy_off", {31'b0, busy}, 32'd0);
        check_eq("t5_bcnt", {16'b0, branch_cnt}, 32'd8);
        check_eq("t5_mcnt", {16'b0, mispredict_cnt}, 32'd3);

        // 6: reset in the middle of a flush
        set_ex(1'b1, 32'h10, 1'b1, 1'b0, 32'h777);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("t6_flush_pre", {31'b0, flush}, 32'd1);
        check_eq("t6_rpc_pre", redirect_pc, 32'h14);
        rst = 1'b1;
        #1;
        check_eq("t6_flush", {31'b0, flush}, 32'd0);
        check_eq("t6_busy", {31'b0, busy}, 32'd0);
        check_eq("t6_redir", {31'b0, redirect}, 32'd0);
        check_eq("t6_bcnt", {16'b0, branch_cnt}, 32'd0);
        check_eq("t6_mcnt", {16'b0, mispredict_cnt}, 32'd0);
        check_eq("t6_rpc", redirect_pc, 32'd0);
        check_eq("t6_pred", {31'b0, pred_taken}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check_eq("t6_post_flush", {31'b0, flush}, 32'd0);
        check_eq("t6_post_pred", {31'b0, pred_taken}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
